// File: rtl/msrv32_load_unit.sv
// msrv32 data-memory load path: word-aligned read request, acknowledge wait with timeout,
// then byte/half/word extraction with sign or zero extension.
//
//   state | meaning
//   IDLE  | no read outstanding, accepting load requests
//   REQ   | word read issued, waiting for acknowledge (pipeline stalled)
//   DONE  | result registered, load_done pulse; may accept the next load directly
module msrv32_load_unit #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        load_req_in,
   input  logic [2:0]  func3_in,
   input  logic [31:0] iaddr_in,
   output logic        ms_riscv32_mp_dmrd_req_out,
   output logic [31:0] ms_riscv32_mp_dmrdaddr_out,
   input  logic        ms_riscv32_mp_dmrd_ack_in,
   input  logic [31:0] ms_riscv32_mp_dmdata_in,
   output logic [31:0] lu_output_out,
   output logic        load_done_out,
   output logic        stall_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state;
   logic [2:0]    func3_q;
   logic [1:0]    offs_q;
   logic [31:0]   waddr_q;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   lu_q;
   logic          done_q;
   logic          misal_q;
   logic          berr_q;

   function automatic logic is_aligned(input logic [2:0] f, input logic [1:0] a);
      logic ok;
      case (f)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = ~a[0];
         default:        ok = (a == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (f)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'b0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'b0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state    <= IDLE;
         func3_q  <= '0;
         offs_q   <= '0;
         waddr_q  <= '0;
         wait_cnt <= '0;
         lu_q     <= '0;
         done_q   <= 1'b0;
         misal_q  <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         misal_q <= 1'b0;
         berr_q  <= 1'b0;
         case (state)
            REQ: begin
               if (ms_riscv32_mp_dmrd_ack_in) begin
                  lu_q   <= extract(func3_q, offs_q, ms_riscv32_mp_dmdata_in);
                  done_q <= 1'b1;
                  state  <= DONE;
               end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
                  berr_q <= 1'b1;
                  state  <= IDLE;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE share the accept path so back-to-back loads need no bubble
               state <= IDLE;
               if (load_req_in) begin
                  if (is_aligned(func3_in, iaddr_in[1:0])) begin
                     func3_q  <= func3_in;
                     offs_q   <= iaddr_in[1:0];
                     waddr_q  <= {iaddr_in[31:2], 2'b00};
                     wait_cnt <= '0;
                     state    <= REQ;
                  end else begin
                     misal_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign ms_riscv32_mp_dmrd_req_out = (state == REQ);
   assign stall_out                  = (state == REQ);
   assign ms_riscv32_mp_dmrdaddr_out = waddr_q;
   assign lu_output_out              = lu_q;
   assign load_done_out              = done_q;
   assign misaligned_out             = misal_q;
   assign bus_err_out                = berr_q;

endmodule

// File: tb/tb_msrv32_load_unit.sv
// Directed bench for msrv32_load_unit with a 4-cycle acknowledge timeout.
module tb_msrv32_load_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_req = 1'b0;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] iaddr = '0;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_data = '0;
   logic [31:0] lu_out;
   logic        done;
   logic        stall;
   logic        misal;
   logic        berr;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   msrv32_load_unit #(.TIMEOUT_CYCLES(4)) dut (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst),
      .load_req_in                (load_req),
      .func3_in                   (func3),
      .iaddr_in                   (iaddr),
      .ms_riscv32_mp_dmrd_req_out (dm_req),
      .ms_riscv32_mp_dmrdaddr_out (dm_addr),
      .ms_riscv32_mp_dmrd_ack_in  (dm_ack),
      .ms_riscv32_mp_dmdata_in    (dm_data),
      .lu_output_out              (lu_out),
      .load_done_out              (done),
      .stall_out                  (stall),
      .misaligned_out             (misal),
      .bus_err_out                (berr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " req"},   {31'b0, dm_req}, 32'd0);
      chk({tag, " addr"},  dm_addr, 32'd0);
      chk({tag, " lu"},    lu_out, 32'd0);
      chk({tag, " done"},  {31'b0, done}, 32'd0);
      chk({tag, " stall"}, {31'b0, stall}, 32'd0);
      chk({tag, " misal"}, {31'b0, misal}, 32'd0);
      chk({tag, " berr"},  {31'b0, berr}, 32'd0);
   endtask

   // Issue one aligned load, hold off the ack for 'waits' REQ cycles, then check the result.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int waits, input logic [31:0] exp);
      load_req = 1'b1;
      func3    = f3;
      iaddr    = addr;
      tick();
      load_req = 1'b0;
      chk({tag, " req"},  {31'b0, dm_req}, 32'd1);
      chk({tag, " addr"}, dm_addr, {addr[31:2], 2'b00});
      for (int i = 0; i < waits; i++) begin
         tick();
         chk({tag, " wait req"}, {31'b0, dm_req}, 32'd1);
      end
      dm_ack  = 1'b1;
      dm_data = data;
      tick();
      dm_ack = 1'b0;
      chk({tag, " done"},  {31'b0, done}, 32'd1);
      chk({tag, " data"},  lu_out, exp);
      chk({tag, " stall"}, {31'b0, stall}, 32'd0);
      tick();
      chk({tag, " done clr"}, {31'b0, done}, 32'd0);
      chk({tag, " hold"}, lu_out, exp);
   endtask

   initial begin
      int req_cycles;

      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      chk_all_zero("post reset idle");

      // LW, ack on first REQ cycle: done pulse two cycles after the request
      load_req = 1'b1;
      func3    = LW;
      iaddr    = 32'h0000_1008;
      tick();
      load_req = 1'b0;
      chk("lw req", {31'b0, dm_req}, 32'd1);
      chk("lw stall", {31'b0, stall}, 32'd1);
      chk("lw addr", dm_addr, 32'h0000_1008);
      chk("lw done early", {31'b0, done}, 32'd0);
      dm_ack  = 1'b1;
      dm_data = 32'hDEAD_BEEF;
      tick();
      dm_ack = 1'b0;
      chk("lw done", {31'b0, done}, 32'd1);
      chk("lw data", lu_out, 32'hDEAD_BEEF);
      chk("lw stall clr", {31'b0, stall}, 32'd0);
      chk("lw req clr", {31'b0, dm_req}, 32'd0);
      tick();
      chk("lw done clr", {31'b0, done}, 32'd0);

      do_load("lb0",  LB,  32'h0000_2000, 32'h80FF_7F01, 0, 32'h0000_0001);
      do_load("lb1",  LB,  32'h0000_2001, 32'h80FF_7F01, 1, 32'h0000_007F);
      do_load("lb2",  LB,  32'h0000_2002, 32'h80FF_7F01, 0, 32'hFFFF_FFFF);
      do_load("lb3",  LB,  32'h0000_2003, 32'h80FF_7F01, 2, 32'hFFFF_FF80);
      do_load("lbu3", LBU, 32'h0000_2003, 32'h80FF_7F01, 0, 32'h0000_0080);
      do_load("lh2",  LH,  32'h0000_2002, 32'h8001_7FFE, 0, 32'hFFFF_8001);
      do_load("lhu2", LHU, 32'h0000_2002, 32'h8001_7FFE, 1, 32'h0000_8001);
      do_load("lh0",  LH,  32'h0000_2000, 32'h8001_7FFE, 0, 32'h0000_7FFE);

      // Misaligned LH then LW: one pulse each, never a memory request
      load_req = 1'b1;
      func3    = LH;
      iaddr    = 32'h0000_1001;
      tick();
      load_req = 1'b0;
      chk("mis lh pulse", {31'b0, misal}, 32'd1);
      chk("mis lh req", {31'b0, dm_req}, 32'd0);
      chk("mis lh lu", lu_out, 32'h0000_7FFE);
      tick();
      chk("mis lh clr", {31'b0, misal}, 32'd0);
      chk("mis lh req2", {31'b0, dm_req}, 32'd0);
      load_req = 1'b1;
      func3    = LW;
      iaddr    = 32'h0000_1002;
      tick();
      load_req = 1'b0;
      chk("mis lw pulse", {31'b0, misal}, 32'd1);
      chk("mis lw req", {31'b0, dm_req}, 32'd0);
      chk("mis lw done", {31'b0, done}, 32'd0);
      tick();
      chk("mis lw clr", {31'b0, misal}, 32'd0);
      chk("mis lw req2", {31'b0, dm_req}, 32'd0);
      chk("mis lw lu", lu_out, 32'h0000_7FFE);

      // Timeout: REQ must last exactly 4 cycles, then bus_err
      load_req = 1'b1;
      func3    = LW;
      iaddr    = 32'h0000_3000;
      tick();
      load_req   = 1'b0;
      req_cycles = 0;
      while (dm_req && req_cycles < 10) begin
         req_cycles++;
         chk("to berr early", {31'b0, berr}, 32'd0);
         tick();
      end
      chk("to req cycles", req_cycles, 32'd4);
      chk("to berr", {31'b0, berr}, 32'd1);
      chk("to lu", lu_out, 32'h0000_7FFE);
      dm_ack  = 1'b1;
      dm_data = 32'hCAFE_F00D;
      tick();
      dm_ack = 1'b0;
      chk("late ack done", {31'b0, done}, 32'd0);
      chk("late ack berr clr", {31'b0, berr}, 32'd0);
      chk("late ack lu", lu_out, 32'h0000_7FFE);
      do_load("to3", LW, 32'h0000_3004, 32'h1234_5678, 3, 32'h1234_5678);

      // Reset on the 2nd REQ cycle; a later ack must not complete anything
      load_req = 1'b1;
      func3    = LW;
      iaddr    = 32'h0000_4000;
      tick();
      load_req = 1'b0;
      tick();
      chk("rst mid req", {31'b0, dm_req}, 32'd1);
      rst = 1'b1;
      tick();
      chk_all_zero("rst mid");
      rst     = 1'b0;
      dm_ack  = 1'b1;
      dm_data = 32'hFFFF_FFFF;
      tick();
      dm_ack = 1'b0;
      chk("rst late done", {31'b0, done}, 32'd0);
      chk("rst late lu", lu_out, 32'd0);
      chk("rst late req", {31'b0, dm_req}, 32'd0);
      tick();
      chk("rst late done2", {31'b0, done}, 32'd0);

      // Back-to-back: B presented during A's DONE cycle
      load_req = 1'b1;
      func3    = LBU;
      iaddr    = 32'h0000_5001;
      tick();
      chk("b2b a req", {31'b0, dm_req}, 32'd1);
      dm_ack  = 1'b1;
      dm_data = 32'hAABB_CCDD;
      tick();
      dm_ack = 1'b0;
      chk("b2b a done", {31'b0, done}, 32'd1);
      chk("b2b a data", lu_out, 32'h0000_00CC);
      func3 = LH;
      iaddr = 32'h0000_5002;
      tick();
      load_req = 1'b0;
      chk("b2b b req", {31'b0, dm_req}, 32'd1);
      chk("b2b b stall", {31'b0, stall}, 32'd1);
      chk("b2b b addr", dm_addr, 32'h0000_5000);
      chk("b2b a hold", lu_out, 32'h0000_00CC);
      dm_ack  = 1'b1;
      dm_data = 32'h9000_1111;
      tick();
      dm_ack = 1'b0;
      chk("b2b b done", {31'b0, done}, 32'd1);
      chk("b2b b data", lu_out, 32'hFFFF_9000);
      tick();
      chk("b2b idle", {31'b0, dm_req}, 32'd0);
      chk("b2b done clr", {31'b0, done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
